complex_dot_product_scheduler: RTL and testbench

Sequencer and arbiter for the shared complex dot-product datapath (complex_vectorXvector_with_control). Up to NUM_REQ clients post dot-product jobs (two vector base addresses plus an element count). The block grants one job at a time in round-robin order and streams the job's chunks from vector memory into the datapath. It then waits for the datapath's finish and returns the tagged result to the owning client.

---
 rtl/complex_dot_product_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_complex_dot_product_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_dot_product_scheduler.sv
// Round-robin job scheduler feeding the shared complex dot-product datapath.
// Define DP_SCHED_TIMEOUT_EN to add a WAIT_FIN watchdog and the timeout output.
module complex_dot_product_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_W        = 16,
    parameter int MEM_LAT       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*32-1:0]      req_len,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_base_a,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_base_b,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr_a,
    output logic [ADDR_W-1:0]          mem_addr_b,
    output logic                       dp_load,
    output logic                       dp_flush,
    output logic [31:0]                dp_total,
    input  logic                       dp_ready,
    input  logic                       dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]   dp_result,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
`ifdef DP_SCHED_TIMEOUT_EN
    output logic                       timeout,
`endif
    output logic [ELEMENT_WIDTH-1:0]   result
);

    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int CHUNK_SH = $clog2(NO_OF_UNITS);

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, FLUSH, WAIT_FIN, REPORT} state_t;

    state_t                     state_q, state_d;
    logic [ID_W-1:0]            rrPtr_q, rrPtr_d;
    logic [ADDR_W-1:0]          baseA_q, baseA_d, baseB_q, baseB_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic [31:0]                chunks_q, chunks_d, k_q, k_d;
    logic                       flushCnt_q, flushCnt_d;
    logic                       memRdEn_q, memRdEn_d;
    logic [ADDR_W-1:0]          addrA_q, addrA_d, addrB_q, addrB_d;
    logic                       flushBeat_q, flushBeat_d;
    logic [MEM_LAT-1:0]         loadPipe_q, flushPipe_q;
    logic                       busy_q, busy_d;
    logic [31:0]                dpTotal_q, dpTotal_d;
    logic                       done_q, done_d;
    logic [ID_W-1:0]            doneId_q, doneId_d;
    logic [ELEMENT_WIDTH-1:0]   result_q, result_d;
`ifdef DP_SCHED_TIMEOUT_EN
    logic [15:0]                wd_q, wd_d;
    logic                       timedOut_q, timedOut_d;
    logic                       timeout_q, timeout_d;
`endif

    logic                       anyReq;
    logic [ID_W-1:0]            winner;
    int                         idx;
    logic [31:0]                lenSel;
    logic [32:0]                lenRound;
    logic [31:0]                chunksCalc;

    // Round-robin search starting at the pointer, wrapping past the last client.
    always_comb begin
        anyReq = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rrPtr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!anyReq && req[idx[ID_W-1:0]]) begin
                anyReq = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign lenSel     = req_len[winner*32 +: 32];
    assign lenRound   = {1'b0, lenSel} + 33'(NO_OF_UNITS - 1);
    assign chunksCalc = 32'(lenRound >> CHUNK_SH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (|req && dp_ready) state_d = GRANT;
            GRANT:    if (!anyReq) state_d = IDLE;
                      else if (lenSel == 32'd0) state_d = REPORT;
                      else state_d = ISSUE;
            ISSUE:    if (k_q == chunks_q - 32'd1) state_d = FLUSH;
            FLUSH:    if (flushCnt_q) state_d = WAIT_FIN;
            WAIT_FIN: begin
                if (dp_finish) state_d = REPORT;
`ifdef DP_SCHED_TIMEOUT_EN
                else if (wd_q == 16'hFFFF) state_d = REPORT;
`endif
            end
            REPORT:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Grant is combinational so the client sees it in the GRANT cycle; everything else is registered.
    always_comb begin
        gnt         = '0;
        rrPtr_d     = rrPtr_q;
        baseA_d     = baseA_q;
        baseB_d     = baseB_q;
        id_d        = id_q;
        chunks_d    = chunks_q;
        k_d         = k_q;
        flushCnt_d  = flushCnt_q;
        memRdEn_d   = 1'b0;
        addrA_d     = addrA_q;
        addrB_d     = addrB_q;
        flushBeat_d = 1'b0;
        busy_d      = busy_q;
        dpTotal_d   = dpTotal_q;
        done_d      = 1'b0;
        doneId_d    = doneId_q;
        result_d    = result_q;
`ifdef DP_SCHED_TIMEOUT_EN
        wd_d        = (state_q == WAIT_FIN) ? wd_q + 16'd1 : 16'd0;
        timedOut_d  = timedOut_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            GRANT: if (anyReq) begin
                gnt[winner] = 1'b1;
                rrPtr_d     = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                baseA_d     = req_base_a[winner*ADDR_W +: ADDR_W];
                baseB_d     = req_base_b[winner*ADDR_W +: ADDR_W];
                id_d        = winner;
                chunks_d    = chunksCalc;
                k_d         = 32'd0;
                flushCnt_d  = 1'b0;
                busy_d      = 1'b1;
                dpTotal_d   = lenSel;
                if (lenSel == 32'd0) result_d = '0;
`ifdef DP_SCHED_TIMEOUT_EN
                timedOut_d  = 1'b0;
`endif
            end
            ISSUE: begin
                memRdEn_d = 1'b1;
                addrA_d   = baseA_q + ADDR_W'(k_q);
                addrB_d   = baseB_q + ADDR_W'(k_q);
                k_d       = k_q + 32'd1;
            end
            FLUSH: begin
                flushBeat_d = 1'b1;
                flushCnt_d  = 1'b1;
            end
            WAIT_FIN: begin
                if (dp_finish) result_d = dp_result;
`ifdef DP_SCHED_TIMEOUT_EN
                else if (wd_q == 16'hFFFF) begin
                    result_d   = '0;
                    timedOut_d = 1'b1;
                end
`endif
            end
            REPORT: begin
                done_d   = 1'b1;
                doneId_d = id_q;
                busy_d   = 1'b0;
`ifdef DP_SCHED_TIMEOUT_EN
                timeout_d = timedOut_q;
`endif
            end
            default: ;
        endcase
    end

    // The load pipe models memory latency; flush beats ride the same pipe so they follow data with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            baseA_q     <= '0;
            baseB_q     <= '0;
            id_q        <= '0;
            chunks_q    <= '0;
            k_q         <= '0;
            flushCnt_q  <= 1'b0;
            memRdEn_q   <= 1'b0;
            addrA_q     <= '0;
            addrB_q     <= '0;
            flushBeat_q <= 1'b0;
            loadPipe_q  <= '0;
            flushPipe_q <= '0;
            busy_q      <= 1'b0;
            dpTotal_q   <= '0;
            done_q      <= 1'b0;
            doneId_q    <= '0;
            result_q    <= '0;
`ifdef DP_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timedOut_q  <= 1'b0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            baseA_q     <= baseA_d;
            baseB_q     <= baseB_d;
            id_q        <= id_d;
            chunks_q    <= chunks_d;
            k_q         <= k_d;
            flushCnt_q  <= flushCnt_d;
            memRdEn_q   <= memRdEn_d;
            addrA_q     <= addrA_d;
            addrB_q     <= addrB_d;
            flushBeat_q <= flushBeat_d;
            loadPipe_q  <= MEM_LAT'({loadPipe_q, memRdEn_q | flushBeat_q});
            flushPipe_q <= MEM_LAT'({flushPipe_q, flushBeat_q});
            busy_q      <= busy_d;
            dpTotal_q   <= dpTotal_d;
            done_q      <= done_d;
            doneId_q    <= doneId_d;
            result_q    <= result_d;
`ifdef DP_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            timedOut_q  <= timedOut_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign mem_rd_en  = memRdEn_q;
    assign mem_addr_a = addrA_q;
    assign mem_addr_b = addrB_q;
    assign dp_load    = loadPipe_q[MEM_LAT-1];
    assign dp_flush   = flushPipe_q[MEM_LAT-1];
    assign dp_total   = dpTotal_q;
    assign done       = done_q;
    assign done_id    = doneId_q;
    assign result     = result_q;
`ifdef DP_SCHED_TIMEOUT_EN
    assign timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_complex_dot_product_scheduler.sv
// Scoreboard bench for complex_dot_product_scheduler: grants, addresses and results
// are queued at stimulus time and checked by an independent monitor.
module tb_complex_dot_product_scheduler;

    localparam int NR  = 4;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_len;
    logic [63:0]  req_base_a, req_base_b;
    logic [3:0]   gnt;
    logic         busy, mem_rd_en, dp_load, dp_flush, dp_ready, dp_finish, done;
    logic [15:0]  mem_addr_a, mem_addr_b;
    logic [31:0]  dp_total;
    logic [63:0]  dp_result, result;
    logic [1:0]   done_id;

    typedef struct { logic [15:0] a; logic [15:0] b; } addr_t;
    typedef struct { int id; logic [63:0] res; } done_t;

    addr_t addrQ[$];
    done_t doneQ[$];
    int    gntQ[$];
    logic [63:0] jobResult [NR];

    int checks = 0, errors = 0;
    int doneCnt = 0, doneTarget = 0, gntCnt = 0;
    int memRdCnt = 0, loadCnt = 0, flushCnt = 0;
    int expMemRd = 0, expLoad = 0, expFlush = 0;

    complex_dot_product_scheduler #(
        .NUM_REQ(NR), .ELEMENT_WIDTH(64), .NO_OF_UNITS(8), .ADDR_W(16), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len),
        .req_base_a(req_base_a), .req_base_b(req_base_b), .gnt(gnt), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .dp_load(dp_load), .dp_flush(dp_flush), .dp_total(dp_total), .dp_ready(dp_ready),
        .dp_finish(dp_finish), .dp_result(dp_result), .done(done), .done_id(done_id),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Queue the expected grant, address stream and result of one job.
    task automatic applyStimulus(input int id, input int len, input logic [15:0] ba,
                                 input logic [15:0] bb, input logic [63:0] res);
        int    chunks;
        addr_t a;
        done_t d;
        chunks = (len + 7) / 8;
        req_len[id*32 +: 32]    = 32'(len);
        req_base_a[id*16 +: 16] = ba;
        req_base_b[id*16 +: 16] = bb;
        jobResult[id] = res;
        gntQ.push_back(id);
        for (int k = 0; k < chunks; k++) begin
            a.a = ba + 16'(k);
            a.b = bb + 16'(k);
            addrQ.push_back(a);
        end
        d.id  = id;
        d.res = (len == 0) ? 64'd0 : res;
        doneQ.push_back(d);
        expMemRd += chunks;
        if (len != 0) begin
            expLoad  += chunks + 2;
            expFlush += 2;
        end
    endtask

    task automatic clearTallies();
        memRdCnt = 0; loadCnt = 0; flushCnt = 0;
        expMemRd = 0; expLoad = 0; expFlush = 0;
    endtask

    task automatic checkTallies(input string tag);
        checkOutput({tag, "_mem_rd_beats"}, 64'(memRdCnt), 64'(expMemRd));
        checkOutput({tag, "_load_beats"}, 64'(loadCnt), 64'(expLoad));
        checkOutput({tag, "_flush_beats"}, 64'(flushCnt), 64'(expFlush));
    endtask

    task automatic waitGrant(input int id);
        int n = 0;
        while (!gnt[id] && n < 200) begin @(negedge clk); n++; end
        checkOutput("grant_seen", 64'(gnt[id]), 64'd1);
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (doneCnt < target && n < 2000) begin @(negedge clk); n++; end
        checkOutput("done_count", 64'(doneCnt), 64'(target));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant, a read or a result.
    logic [2:0] hist = '0;
    logic       prevLoad = 1'b0;
    int         expG;
    addr_t      expA;
    done_t      expD;
    always @(negedge clk) begin
        if (reset) begin
            hist     = '0;
            prevLoad = 1'b0;
        end else begin
            if (gnt != 4'd0) begin
                gntCnt++;
                checkOutput("gnt_onehot", 64'($onehot(gnt)), 64'd1);
                if (gntQ.size() == 0) checkOutput("gnt_unexpected", 64'(gnt), 64'd0);
                else begin
                    expG = gntQ.pop_front();
                    checkOutput("gnt_id", 64'(gnt), 64'(4'b0001 << expG));
                end
            end
            if (mem_rd_en) begin
                memRdCnt++;
                if (addrQ.size() == 0) checkOutput("rd_unexpected", 64'(mem_rd_en), 64'd0);
                else begin
                    expA = addrQ.pop_front();
                    checkOutput("mem_addr_a", 64'(mem_addr_a), 64'(expA.a));
                    checkOutput("mem_addr_b", 64'(mem_addr_b), 64'(expA.b));
                end
            end
            if (dp_load) loadCnt++;
            if (dp_flush) begin
                flushCnt++;
                checkOutput("flush_contiguous", 64'(prevLoad), 64'd1);
            end
            if (hist[2] || (dp_load && !dp_flush))
                checkOutput("load_lag", 64'(dp_load && !dp_flush), 64'(hist[2]));
            if (done) begin
                doneCnt++;
                if (doneQ.size() == 0) checkOutput("done_unexpected", 64'(done), 64'd0);
                else begin
                    expD = doneQ.pop_front();
                    checkOutput("done_id", 64'(done_id), 64'(expD.id));
                    checkOutput("result", result, expD.res);
                end
            end
            prevLoad = dp_load;
            hist     = {hist[1:0], mem_rd_en};
        end
    end

    // Client and datapath responder: drop req after the grant edge, answer finish after the second flush.
    int         curId = 0, flSeen = 0, finCd = 0;
    logic [3:0] dropMask = '0;
    always @(negedge clk) begin
        dp_finish = 1'b0;
        if (reset) begin
            flSeen = 0;
            finCd  = 0;
        end else begin
            for (int i = 0; i < NR; i++)
                if (gnt[i]) begin
                    curId       = i;
                    dropMask[i] = 1'b1;
                end
            if (finCd != 0) begin
                finCd--;
                if (finCd == 0) begin
                    dp_finish = 1'b1;
                    dp_result = jobResult[curId];
                end
            end
            if (dp_flush) begin
                flSeen++;
                if (flSeen == 2) begin
                    flSeen = 0;
                    finCd  = 2;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        req      = req & ~dropMask;
        dropMask = '0;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset = 1'b1; req = '0; req_len = '0; req_base_a = '0; req_base_b = '0;
        dp_ready = 1'b1; dp_finish = 1'b0; dp_result = '0;
        for (int i = 0; i < NR; i++) jobResult[i] = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 64'(gnt), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        checkOutput("rst_addr_a", 64'(mem_addr_a), 64'd0);
        checkOutput("rst_addr_b", 64'(mem_addr_b), 64'd0);
        checkOutput("rst_dp_load", 64'(dp_load), 64'd0);
        checkOutput("rst_dp_flush", 64'(dp_flush), 64'd0);
        checkOutput("rst_dp_total", 64'(dp_total), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_result", result, 64'd0);
        reset = 1'b0;

        $display("[TB] single job, len 16");
        clearTallies();
        applyStimulus(0, 16, 16'h0010, 16'h0020, 64'h0000_0003_0000_0004);
        doneTarget++;
        req[0] = 1'b1;
        waitGrant(0);
        @(negedge clk);
        checkOutput("t1_dp_total", 64'(dp_total), 64'd16);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        waitDone(doneTarget);
        checkTallies("t1");
        checkOutput("t1_busy_after", 64'(busy), 64'd0);

        $display("[TB] partial chunk, len 9, address wrap");
        clearTallies();
        applyStimulus(1, 9, 16'hFFFF, 16'h0100, 64'h0000_0005_FFFF_FFFB);
        doneTarget++;
        req[1] = 1'b1;
        waitGrant(1);
        @(negedge clk);
        checkOutput("t2_dp_total", 64'(dp_total), 64'd9);
        waitDone(doneTarget);
        checkTallies("t2");

        $display("[TB] zero length");
        clearTallies();
        applyStimulus(3, 0, 16'h0050, 16'h0060, 64'hDEAD_BEEF_0000_0001);
        doneTarget++;
        req[3] = 1'b1;
        waitGrant(3);
        @(negedge clk);
        checkOutput("t3_busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("t3_done_latency", 64'(done), 64'd1);
        waitDone(doneTarget);
        checkTallies("t3");

        $display("[TB] round robin, all four clients");
        clearTallies();
        for (int i = 0; i < NR; i++)
            applyStimulus(i, 8, 16'(16'h0100 + i * 16), 16'(16'h0200 + i * 16),
                          {32'(i + 1), 32'(i * 3 + 7)});
        doneTarget += 4;
        req = 4'b1111;
        waitDone(doneTarget);
        checkTallies("t4a");

        $display("[TB] round robin, clients 0 and 2 again");
        clearTallies();
        applyStimulus(0, 24, 16'h0500, 16'h0600, 64'h1111_2222_3333_4444);
        applyStimulus(2, 1, 16'h0700, 16'h0800, 64'h0000_0000_0000_0009);
        doneTarget += 2;
        req[0] = 1'b1;
        req[2] = 1'b1;
        waitDone(doneTarget);
        checkTallies("t4b");

        $display("[TB] reset during ISSUE");
        clearTallies();
        applyStimulus(0, 64, 16'h0040, 16'h0080, 64'h0BAD_0BAD_0BAD_0BAD);
        req[0] = 1'b1;
        waitGrant(0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        addrQ.delete();
        doneQ.delete();
        @(negedge clk);
        checkOutput("t5_mem_rd_en", 64'(mem_rd_en), 64'd0);
        checkOutput("t5_addr_a", 64'(mem_addr_a), 64'd0);
        checkOutput("t5_dp_load", 64'(dp_load), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_dp_total", 64'(dp_total), 64'd0);
        checkOutput("t5_result", result, 64'd0);
        #1;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("t5_no_done", 64'(doneCnt), 64'(doneTarget));
        clearTallies();
        applyStimulus(1, 8, 16'h0900, 16'h0A00, 64'h0000_0042_0000_0043);
        doneTarget++;
        req[1] = 1'b1;
        waitGrant(1);
        waitDone(doneTarget);
        checkTallies("t5");

        $display("[TB] dp_ready low holds off grant");
        clearTallies();
        dp_ready = 1'b0;
        applyStimulus(2, 17, 16'h0300, 16'h0400, 64'h7777_0000_0000_8888);
        doneTarget++;
        expG = gntCnt;
        req[2] = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("t6_no_grant", 64'(gntCnt), 64'(expG));
        dp_ready = 1'b1;
        waitGrant(2);
        @(negedge clk);
        checkOutput("t6_dp_total", 64'(dp_total), 64'd17);
        waitDone(doneTarget);
        checkTallies("t6");

        repeat (4) @(negedge clk);
        checkOutput("end_addr_queue", 64'(addrQ.size()), 64'd0);
        checkOutput("end_done_queue", 64'(doneQ.size()), 64'd0);
        checkOutput("end_gnt_queue", 64'(gntQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
